tour_cmd_sequencer: RTL and testbench

Sequences a solved knight's tour into the motion datapath. It sits between the UART command path (RemoteComm-facing wrapper), the tour solution memory and cmd_proc. While idle it forwards UART commands unchanged. After start_tour it owns the cmd_proc command port and converts each stored knight move into two commands, a vertical leg then a horizontal leg. It returns 8'h5A per leg and 8'hA5 after the final leg.

---
 rtl/tour_cmd_sequencer.sv | 141 ++++++++++++++
 tb/tb_tour_cmd_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd_sequencer.sv
// Knight's-tour command sequencer: forwards UART commands while idle, and during a
// tour turns each stored knight move into a vertical leg followed by a horizontal leg.
module tour_cmd_sequencer #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    typedef enum logic [2:0] {IDLE, LOAD, Y_MOVE, Y_WAIT, X_MOVE, X_WAIT} state_t;

    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

    state_t            state;
    state_t            nxt_state;
    logic signed [2:0] dx;
    logic signed [2:0] dy;
    logic              clr_indx;
    logic              inc_indx;
    logic              load_delta;
    logic              last_move;
    logic [15:0]       y_cmd;
    logic [15:0]       x_cmd;

    // Returns {dx, dy}; the lowest set bit selects the move, and an empty byte acts as bit 0.
    function automatic logic [5:0] decode_move(input logic [7:0] mv);
        logic [2:0]        k;
        logic signed [2:0] dxl;
        logic signed [2:0] dyl;
        k = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mv[i]) k = 3'(i);
        end
        case (k)
            3'd0:    begin dxl =  3'sd1; dyl =  3'sd2; end
            3'd1:    begin dxl = -3'sd1; dyl =  3'sd2; end
            3'd2:    begin dxl = -3'sd2; dyl =  3'sd1; end
            3'd3:    begin dxl = -3'sd2; dyl = -3'sd1; end
            3'd4:    begin dxl = -3'sd1; dyl = -3'sd2; end
            3'd5:    begin dxl =  3'sd1; dyl = -3'sd2; end
            3'd6:    begin dxl =  3'sd2; dyl = -3'sd1; end
            default: begin dxl =  3'sd2; dyl =  3'sd1; end
        endcase
        return {dxl, dyl};
    endfunction

    function automatic logic [3:0] magnitude(input logic signed [2:0] v);
        logic signed [2:0] neg;
        neg = -v;
        return v[2] ? {1'b0, neg} : {1'b0, v};
    endfunction

    assign last_move = (mv_indx == LAST_INDX);

    assign y_cmd = {4'b0010, (dy[2] ? 8'h7F : 8'h00), magnitude(dy)};
    assign x_cmd = {4'b0011, (dx[2] ? 8'h3F : 8'hBF), magnitude(dx)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mv_indx <= 5'd0;
            dx      <= 3'sd0;
            dy      <= 3'sd0;
        end else begin
            state <= nxt_state;
            if (clr_indx) begin
                mv_indx <= 5'd0;
            end else if (inc_indx) begin
                mv_indx <= mv_indx + 5'd1;
            end
            if (load_delta) begin
                {dx, dy} <= decode_move(move);
            end
        end
    end

    // Outside IDLE every output is decoded from state and the registered leg deltas.
    always_comb begin
        nxt_state        = state;
        cmd              = y_cmd;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = 8'h5A;
        clr_indx         = 1'b0;
        inc_indx         = 1'b0;
        load_delta       = 1'b0;
        case (state)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = 8'hA5;
                if (start_tour) begin
                    clr_indx  = 1'b1;
                    nxt_state = LOAD;
                end
            end
            LOAD: begin
                load_delta = 1'b1;
                nxt_state  = Y_MOVE;
            end
            Y_MOVE: begin
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) nxt_state = Y_WAIT;
            end
            Y_WAIT: begin
                if (send_resp) nxt_state = X_MOVE;
            end
            X_MOVE: begin
                cmd     = x_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) nxt_state = X_WAIT;
            end
            X_WAIT: begin
                cmd = x_cmd;
                if (last_move) resp = 8'hA5;
                if (send_resp) begin
                    if (last_move) begin
                        nxt_state = IDLE;
                    end else begin
                        inc_indx  = 1'b1;
                        nxt_state = LOAD;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Bench for tour_cmd_sequencer: a cmd_proc/UART stimulus driver plus a per-cycle
// comparator against expectations derived from the knight-move table.
module tb_tour_cmd_sequencer;

    localparam int NUM_MOVES = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    always #5 clk = ~clk;

    tour_cmd_sequencer #(.NUM_MOVES(NUM_MOVES)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp)
    );

    // Solution memory with asynchronous read
    logic [7:0] mem [0:NUM_MOVES-1];
    assign move = (mv_indx < 5'(NUM_MOVES)) ? mem[mv_indx] : 8'h00;

    int dx_tab [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int dy_tab [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

    int checks = 0;
    int errors = 0;

    int          exp_mode = 0;   // 0 none, 1 idle passthrough, 2 touring
    logic        exp_rdy;
    logic [15:0] exp_cmd;
    bit          exp_cmd_vld;
    logic [7:0]  exp_resp;
    logic [4:0]  exp_mv = 5'd0;

    logic [15:0] got_cmd  [0:63];
    logic [7:0]  got_resp [0:63];
    int          n_got;
    int          n_resp;

    function automatic int lowest_bit(input logic [7:0] m);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [15:0] model_cmd(input logic [7:0] m, input bit horiz);
        int         d;
        logic [7:0] h;
        logic [3:0] op;
        d = horiz ? dx_tab[lowest_bit(m)] : dy_tab[lowest_bit(m)];
        if (horiz) begin
            op = 4'h3;
            h  = (d > 0) ? 8'hBF : 8'h3F;
        end else begin
            op = 4'h2;
            h  = (d > 0) ? 8'h00 : 8'h7F;
        end
        return {op, h, 4'((d < 0) ? -d : d)};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_mode == 1) begin
            chk("idle_cmd", cmd, cmd_UART);
            chk("idle_cmd_rdy", 16'(cmd_rdy), 16'(cmd_rdy_UART));
            chk("idle_clr_uart", 16'(clr_cmd_rdy_UART), 16'(clr_cmd_rdy));
            chk("idle_resp", 16'(resp), 16'h00A5);
            chk("idle_mv_indx", 16'(mv_indx), 16'(exp_mv));
        end else if (exp_mode == 2) begin
            chk("tour_cmd_rdy", 16'(cmd_rdy), 16'(exp_rdy));
            chk("tour_clr_uart", 16'(clr_cmd_rdy_UART), 16'h0000);
            chk("tour_resp", 16'(resp), 16'(exp_resp));
            chk("tour_mv_indx", 16'(mv_indx), 16'(exp_mv));
            if (exp_cmd_vld) chk("tour_cmd", cmd, exp_cmd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One leg, entered one step after the edge into its MOVE state.
    task automatic leg(input int m, input bit horiz, input int abort_move, output bit aborted);
        int hold;
        aborted     = 1'b0;
        exp_rdy     = 1'b1;
        exp_cmd     = model_cmd(mem[m], horiz);
        exp_cmd_vld = 1'b1;
        exp_resp    = 8'h5A;
        got_cmd[n_got] = cmd;
        n_got++;
        hold = (m + int'(horiz)) % 3;
        for (int i = 0; i < hold; i++) begin
            send_resp = (hold == 2);
            tick();
            send_resp = 1'b0;
        end
        clr_cmd_rdy = 1'b1;
        send_resp   = (m % 5 == 0);
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        exp_rdy  = 1'b0;
        exp_resp = (horiz && m == NUM_MOVES - 1) ? 8'hA5 : 8'h5A;
        if (!horiz && m == abort_move) begin
            #2 rst = 1'b1;
            #1;
            chk("abort_cmd_rdy", 16'(cmd_rdy), 16'h0000);
            chk("abort_mv_indx", 16'(mv_indx), 16'h0000);
            chk("abort_resp", 16'(resp), 16'h00A5);
            exp_mode = 1;
            exp_mv   = 5'd0;
            @(posedge clk);
            #1 rst = 1'b0;
            aborted = 1'b1;
            return;
        end
        hold = (m % 3) + 1;
        for (int i = 0; i < hold; i++) begin
            clr_cmd_rdy = (m % 4 == 1);
            start_tour  = (m % 7 == 3);
            tick();
            clr_cmd_rdy = 1'b0;
            start_tour  = 1'b0;
        end
        got_resp[n_resp] = resp;
        n_resp++;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
    endtask

    task automatic run_tour(input int abort_move, input int uart_move);
        bit ab;
        n_got  = 0;
        n_resp = 0;
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        for (int m = 0; m < NUM_MOVES; m++) begin
            exp_mode    = 2;
            exp_mv      = 5'(m);
            exp_rdy     = 1'b0;
            exp_cmd_vld = 1'b0;
            exp_resp    = 8'h5A;
            if (m == uart_move) begin
                cmd_UART     = 16'hBEEF;
                cmd_rdy_UART = 1'b1;
            end
            tick();
            leg(m, 1'b0, abort_move, ab);
            if (ab) return;
            leg(m, 1'b1, abort_move, ab);
        end
        exp_mode = 1;
    endtask

    task automatic check_full_tour(input string tag);
        chk({tag, "_n_cmds"}, 16'(n_got), 16'd48);
        chk({tag, "_n_resps"}, 16'(n_resp), 16'd48);
        for (int i = 0; i < 48; i++) begin
            chk({tag, "_cmd"}, got_cmd[i], model_cmd(mem[i / 2], (i % 2) == 1));
            chk({tag, "_resp"}, 16'(got_resp[i]), (i == 47) ? 16'h00A5 : 16'h005A);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        start_tour   = 1'b0;
        cmd_UART     = 16'h0000;
        cmd_rdy_UART = 1'b1;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        for (int i = 0; i < NUM_MOVES; i++) mem[i] = 8'h01;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd", cmd, 16'h0000);
        chk("rst_cmd_rdy", 16'(cmd_rdy), 16'h0001);
        chk("rst_resp", 16'(resp), 16'h00A5);
        chk("rst_mv_indx", 16'(mv_indx), 16'h0000);
        rst      = 1'b0;
        exp_mode = 1;
        tick();
        clr_cmd_rdy = 1'b1;
        #1 chk("idle_clr_pulse_hi", 16'(clr_cmd_rdy_UART), 16'h0001);
        tick();
        clr_cmd_rdy = 1'b0;
        #1 chk("idle_clr_pulse_lo", 16'(clr_cmd_rdy_UART), 16'h0000);
        cmd_rdy_UART = 1'b0;
        tick();

        // Single decoded moves, each aborted once move 1 reaches Y_WAIT
        mem[0] = 8'h01; mem[1] = 8'h02;
        run_tour(1, -1);
        chk("mv_bit0_y", got_cmd[0], 16'h2002);
        chk("mv_bit0_x", got_cmd[1], 16'h3BF1);
        chk("mv_bit0_resp", 16'(got_resp[0]), 16'h005A);
        tick();

        mem[0] = 8'h08;
        run_tour(1, -1);
        chk("mv_bit3_y", got_cmd[0], 16'h27F1);
        chk("mv_bit3_x", got_cmd[1], 16'h33F2);
        tick();

        mem[0] = 8'h40;
        run_tour(1, -1);
        chk("mv_bit6_y", got_cmd[0], 16'h27F1);
        chk("mv_bit6_x", got_cmd[1], 16'h3BF2);
        tick();

        // Full tour with a UART command arriving at move 5
        mem = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h0C, 8'h00, 8'h81, 8'h30, 8'h01, 8'h80, 8'h40, 8'h20,
                8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h03, 8'hFF, 8'h80};
        run_tour(-1, 5);
        check_full_tour("tour1");
        chk("tour1_end_mv_indx", 16'(mv_indx), 16'd23);
        chk("uart_fwd_cmd", cmd, 16'hBEEF);
        chk("uart_fwd_rdy", 16'(cmd_rdy), 16'h0001);
        clr_cmd_rdy = 1'b1;
        #1 chk("uart_fwd_clr", 16'(clr_cmd_rdy_UART), 16'h0001);
        tick();
        clr_cmd_rdy  = 1'b0;
        cmd_rdy_UART = 1'b0;
        cmd_UART     = 16'h1234;
        tick();
        chk("post_tour_cmd_rdy", 16'(cmd_rdy), 16'h0000);

        // Reset in Y_WAIT of move 10, then a clean restart
        run_tour(10, -1);
        chk("abort_n_cmds", 16'(n_got), 16'd21);
        tick();
        run_tour(-1, -1);
        check_full_tour("tour2");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
